// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hcu_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         STAT_W_DEFAULT = 16;

  // True when destination d feeds a source operand of the instruction in ID.
  function automatic logic reg_match(input logic [4:0] d,
                                     input logic       valid,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return valid && (d != REG_ZERO) && ((d == rs) || (uses_rt && (d == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; async active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard controller: Mealy stall/flush sequencing plus stall/flush statistics.
// Define HAZ_FORWARDING_EN when the forwarding unit is present (only load-use then stalls).
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_MemRead,
  input  logic              ex_RegWrite,
  input  logic [4:0]        ex_dest,
  input  logic              mem_RegWrite,
  input  logic [4:0]        mem_dest,
  input  logic              mem_branch_taken,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              ctrl_bubble,
  output logic              IFID_flush,
  output logic              IDEX_flush,
  output logic              EXMEM_flush,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  hcu_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] haz_len;
  logic       stall;
  logic       flush;

`ifdef HAZ_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_RegWrite, mem_RegWrite, mem_dest};
  assign haz_len = (ex_MemRead && reg_match(ex_dest, id_valid, id_rs, id_rt, id_uses_rt))
                   ? 2'd1 : 2'd0;
`else
  logic unused_nofwd;
  assign unused_nofwd = ex_MemRead;
  assign haz_len = (ex_RegWrite && reg_match(ex_dest, id_valid, id_rs, id_rt, id_uses_rt))
                   ? 2'd2
                 : (mem_RegWrite && reg_match(mem_dest, id_valid, id_rs, id_rt, id_uses_rt))
                   ? 2'd1 : 2'd0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (mem_branch_taken) begin
      // A taken branch squashes the stalled instruction, so the stall is dropped.
      flush   = 1'b1;
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (haz_len != 2'd0) begin
            stall = 1'b1;
          end
          if (haz_len == 2'd2) begin
            state_d = STALL;
            cnt_d   = 2'd1;
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCWrite     = ~stall;
  assign IFIDWrite   = ~stall;
  assign ctrl_bubble = stall;
  assign IFID_flush  = flush;
  assign IDEX_flush  = flush;
  assign EXMEM_flush = flush;

  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (stall),
    .count_o (stall_cycles)
  );

  sat_counter #(.WIDTH(STAT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (flush),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit (default and HAZ_FORWARDING_EN builds).
module tb_hazard_control_unit;

  localparam int STAT_W = 16;
  // {PCWrite, IFIDWrite, ctrl_bubble, IFID_flush, IDEX_flush, EXMEM_flush}
  localparam logic [5:0] PASS_V  = 6'b110_000;
  localparam logic [5:0] STALL_V = 6'b001_000;
  localparam logic [5:0] FLUSH_V = 6'b110_111;
  localparam logic [STAT_W-1:0] SAT_MAX = {STAT_W{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rt, ex_MemRead, ex_RegWrite, mem_RegWrite, mem_branch_taken;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic PCWrite, IFIDWrite, ctrl_bubble, IFID_flush, IDEX_flush, EXMEM_flush;
  logic [STAT_W-1:0] stall_cycles, flush_events;

  typedef struct {
    string             tag;
    logic [5:0]        vec;
    logic [STAT_W-1:0] stalls;
    logic [STAT_W-1:0] flushes;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;
  logic [STAT_W-1:0] exp_stalls = '0;
  logic [STAT_W-1:0] exp_flushes = '0;

  hazard_control_unit #(.STAT_W(STAT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_MemRead       (ex_MemRead),
    .ex_RegWrite      (ex_RegWrite),
    .ex_dest          (ex_dest),
    .mem_RegWrite     (mem_RegWrite),
    .mem_dest         (mem_dest),
    .mem_branch_taken (mem_branch_taken),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .ctrl_bubble      (ctrl_bubble),
    .IFID_flush       (IFID_flush),
    .IDEX_flush       (IDEX_flush),
    .EXMEM_flush      (EXMEM_flush),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] out_vec();
    return {PCWrite, IFIDWrite, ctrl_bubble, IFID_flush, IDEX_flush, EXMEM_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic erw,
                       input logic [4:0] ed, input logic mrw, input logic [4:0] md,
                       input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_MemRead = mr; ex_RegWrite = erw; ex_dest = ed;
    mem_RegWrite = mrw; mem_dest = md; mem_branch_taken = br;
  endtask

  // Push the expectation for this cycle, compare at the falling edge, then advance.
  task automatic step(input string tag, input logic [5:0] vec);
    exp_t e, got;
    e.tag = tag; e.vec = vec; e.stalls = exp_stalls; e.flushes = exp_flushes;
    exp_q.push_back(e);
    if (vec == STALL_V && exp_stalls != SAT_MAX) exp_stalls = exp_stalls + 1'b1;
    if (vec == FLUSH_V && exp_flushes != SAT_MAX) exp_flushes = exp_flushes + 1'b1;
    @(negedge clk);
    got = exp_q.pop_front();
    check({got.tag, "_ctl"},   32'(out_vec()),     32'(got.vec));
    check({got.tag, "_stall"}, 32'(stall_cycles),  32'(got.stalls));
    check({got.tag, "_flush"}, 32'(flush_events),  32'(got.flushes));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset_ctl",   32'(out_vec()),    32'(PASS_V));
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_flush", 32'(flush_events), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef HAZ_FORWARDING_EN
    drive(1, 5'd1, 5'd2, 0, 1, 1, 5'd1, 0, 0, 0);
    step("loaduse", STALL_V);
    drive(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 5'd1, 0);
    step("loaduse_after", PASS_V);
    drive(1, 5'd7, 5'd2, 0, 0, 1, 5'd7, 1, 5'd7, 0);
    step("alu_fwd", PASS_V);
    drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 5'd0, 0);
    step("zero_reg", PASS_V);
    drive(1, 5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0);
    step("rt_unused", PASS_V);
    drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
    step("rt_used", STALL_V);
    drive(0, 5'd5, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
    step("id_invalid", PASS_V);
    drive(1, 5'd4, 5'd2, 0, 1, 1, 5'd4, 0, 0, 1);
    step("br_with_haz", FLUSH_V);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_br", PASS_V);
`else
    drive(1, 5'd1, 5'd3, 1, 0, 1, 5'd3, 0, 0, 0);
    step("ex_haz1", STALL_V);
    drive(1, 5'd1, 5'd3, 1, 0, 0, 5'd0, 0, 0, 0);
    step("ex_haz2", STALL_V);
    drive(1, 5'd1, 5'd3, 1, 0, 0, 5'd0, 1, 5'd3, 0);
    step("mem_haz", STALL_V);
    drive(1, 5'd1, 5'd3, 1, 0, 0, 5'd0, 0, 5'd3, 0);
    step("haz_clear", PASS_V);
    drive(1, 5'd9, 5'd2, 0, 0, 0, 5'd0, 1, 5'd9, 0);
    step("mem_only", STALL_V);
    drive(1, 5'd9, 5'd2, 0, 0, 0, 5'd0, 0, 5'd0, 0);
    step("mem_only_done", PASS_V);
    drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 5'd0, 0);
    step("zero_reg", PASS_V);
    drive(1, 5'd1, 5'd5, 0, 1, 1, 5'd5, 1, 5'd5, 0);
    step("rt_unused", PASS_V);
    drive(0, 5'd5, 5'd5, 1, 1, 1, 5'd5, 1, 5'd5, 0);
    step("id_invalid", PASS_V);
    drive(1, 5'd6, 5'd2, 0, 0, 1, 5'd6, 0, 0, 0);
    step("pre_br_stall", STALL_V);
    drive(1, 5'd6, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1);
    step("br_in_stall", FLUSH_V);
    drive(1, 5'd6, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
    step("after_br_run", PASS_V);
    drive(1, 5'd8, 5'd2, 0, 0, 1, 5'd8, 0, 0, 1);
    step("br_with_haz", FLUSH_V);
    drive(1, 5'd8, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0);
    step("after_br2", PASS_V);

    drive(1, 5'd4, 5'd2, 0, 0, 1, 5'd4, 0, 0, 0);
    step("rst_pre_stall", STALL_V);
`endif

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ctl",   32'(out_vec()),    32'(PASS_V));
    check("midrst_stall", 32'(stall_cycles), 32'd0);
    check("midrst_flush", 32'(flush_events), 32'd0);
    exp_stalls  = '0;
    exp_flushes = '0;
    #1;
    rst_n = 1'b1;
    drive(1, 5'd2, 5'd3, 1, 0, 0, 5'd0, 0, 0, 0);
    step("post_rst_run", PASS_V);

    // Hold a one-cycle hazard so every cycle stalls until the counter saturates.
`ifdef HAZ_FORWARDING_EN
    drive(1, 5'd2, 5'd3, 0, 1, 0, 5'd2, 0, 0, 0);
`else
    drive(1, 5'd2, 5'd3, 0, 0, 0, 5'd0, 1, 5'd2, 0);
`endif
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    exp_stalls = SAT_MAX;
    step("sat_hold1", STALL_V);
    step("sat_hold2", STALL_V);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the five-stage MIPS core. Sits beside the decode stage, compares the instruction held in IF/ID against destinations in ID/EX and EX/MEM, and sequences stalls (PC and IF/ID hold, bubble into ID/EX) and branch flushes (IF/ID, ID/EX, EX/MEM clear). Keeps saturating stall and flush event counters for performance debug.

## Interface
- STAT_W, 16, width of both statistics counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  5  instruction[25:21] in ID
- id_rt  in  5  instruction[20:16] in ID
- id_uses_rt  in  1  rt is a source (R-type, sw, beq)
- ex_MemRead  in  1  ID/EX MemRead
- ex_RegWrite  in  1  ID/EX RegWrite
- ex_dest  in  5  ID/EX destination after RegDst mux
- mem_RegWrite  in  1  EX/MEM RegWrite
- mem_dest  in  5  EX/MEM destination
- mem_branch_taken  in  1  branch resolved taken in MEM this cycle
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID update enable
- ctrl_bubble  out  1  force all ID/EX control bits to 0
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  synchronous clear of that pipeline register at next edge
- stall_cycles  out  STAT_W  saturating count of stalled cycles
- flush_events  out  STAT_W  saturating count of taken-branch flushes

## Operation
- Match(d) = id_valid & (d != 0) & (d == id_rs | (id_uses_rt & d == id_rt)).
- Hazard length N (see Configuration): 0, 1 or 2 cycles.
- States: RUN, STALL; 2-bit down-counter cnt.
- RUN: N=0 → pass (PCWrite=IFIDWrite=1, bubble=0). N≥1 → stall asserted this cycle (PCWrite=0, IFIDWrite=0, ctrl_bubble=1); N=2 → next state STALL, cnt=1; N=1 → stay RUN.
- STALL: stall asserted, no re-evaluation; cnt decrements; cnt==1 at edge → RUN, cnt=0.
- mem_branch_taken overrides everything in either state: all three flush outputs 1, PCWrite=1, IFIDWrite=1, ctrl_bubble=0; next state RUN, cnt=0; flush_events +1.
- stall_cycles +1 on every cycle with stall asserted; both counters hold at 2^STAT_W-1.
- Register 0 never causes a hazard. WB-stage writes need no stall (register file writes first half-cycle).

## Timing
- Control outputs are Mealy: combinational from state and current inputs, acted on by the pipeline registers at the next rising edge.
- Reset (async, any time including mid-stall): state RUN, cnt 0, counters 0; outputs immediately PCWrite=1, IFIDWrite=1, bubble=0, flushes 0 (given no hazard inputs).
- Stall latency: zero cycles from hazard presence to stall outputs.
- Branch and hazard in same cycle: flush only, stall_cycles unchanged.
- id_valid=0: never stalls.

## Configuration
- HAZ_FORWARDING_EN defined: forwarding unit present; N=1 iff ex_MemRead & Match(ex_dest) (load-use), else 0.
- Undefined: no forwarding; N=2 if ex_RegWrite & Match(ex_dest); else N=1 if mem_RegWrite & Match(mem_dest); else 0.

## Structure
- mips_pkg: state type (RUN, STALL), REG_ZERO=5'd0, default STAT_W.
- One sub-module: sat_counter (width param, inc, async active-low clear), instantiated twice for the statistics.

## Test plan
- Reset mid-stall: no-forward build, trigger 2-cycle stall, pull rst_n low after one cycle → PCWrite=1 immediately, stall_cycles=0, state RUN.
- Forwarding build, ex_MemRead=1, ex_dest=1, id_rs=1 → exactly one cycle PCWrite=0, ctrl_bubble=1; stall_cycles=1.
- No-forward build, ex_RegWrite=1, ex_dest=3, id_rt=3, id_uses_rt=1 → two stall cycles; mem_dest=3 match alone → one.
- ex_dest=0 with id_rs=0, RegWrite/MemRead=1 → no stall; id_uses_rt=0 with rt match only → no stall.
- mem_branch_taken during STALL → three flushes 1, PCWrite=1, next cycle RUN, flush_events=1.
- Force 70000 stall cycles → stall_cycles stops at 0xFFFF.
